// File: rtl/alu_add_seq_pkg.sv
// ============================================================================
// Module      : alu_pkg
// Description : Shared types and constants for the byte-serial adder
//               sequencer. Holds the sequencer state encoding, flag bit
//               positions within out_flags, and the operand width.
// Ports       : none (package)
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package alu_pkg;

    localparam int DATA_W = 8;

    // Bit positions inside the 3-bit flag vector {V, N, Z}
    localparam int FLAG_Z = 0;
    localparam int FLAG_N = 1;
    localparam int FLAG_V = 2;

    typedef enum logic [1:0] {
        LOAD_A = 2'd0,
        LOAD_B = 2'd1,
        EXEC   = 2'd2,
        OUT    = 2'd3
    } state_t;

endpackage

`default_nettype wire

// File: rtl/alu_add_seq_addition.sv
// ============================================================================
// Module      : addition
// Description : 8-bit unsigned combinational adder, no carry-in.
// Ports       : A, B      - operands
//               ADD_Out   - A+B mod 256
//               CarryOut  - bit 8 of the 9-bit sum
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module addition
    import alu_pkg::*;
(
    input  logic [DATA_W-1:0] A,
    input  logic [DATA_W-1:0] B,
    output logic [DATA_W-1:0] ADD_Out,
    output logic              CarryOut
);

    assign {CarryOut, ADD_Out} = {1'b0, A} + {1'b0, B};

endmodule

`default_nettype wire

// File: rtl/alu_add_seq.sv
// ============================================================================
// Module      : alu_add_seq
// Description : Byte-serial operand sequencer around the 8-bit adder. Takes
//               operand A then B over a valid/ready byte stream, registers
//               sum, carry and (optionally) flags, and presents them on a
//               valid/ready result stream. With ACCUM=1 each result is fed
//               back as the next A operand (running total); acc_clr drops
//               the running total while waiting for B.
// Macro       : ALU_ADD_SEQ_FLAGS_EN - when defined, out_flags carries
//               {overflow, negative, zero}; otherwise it is tied to 3'b000.
// Ports       : clk, rst_n           - clock, async active-low reset
//               in_valid/in_ready    - operand byte handshake
//               in_data              - operand byte (A first, then B)
//               acc_clr              - ACCUM=1: discard running total
//               out_valid/out_ready  - result handshake
//               out_sum, out_carry   - registered sum and carry-out
//               out_flags            - registered {V, N, Z}
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module alu_add_seq
    import alu_pkg::*;
#(
    parameter bit ACCUM = 1'b0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic              acc_clr,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_sum,
    output logic              out_carry,
    output logic [2:0]        out_flags
);

    state_t            state;
    logic [DATA_W-1:0] reg_a;
    logic [DATA_W-1:0] reg_b;
    logic [DATA_W-1:0] add_sum;
    logic              add_carry;

    addition u_addition (
        .A        (reg_a),
        .B        (reg_b),
        .ADD_Out  (add_sum),
        .CarryOut (add_carry)
    );

    // in_ready depends on acc_clr in LOAD_B so a clear request never
    // coincides with a B byte being taken.
    always_comb begin
        in_ready = 1'b0;
        case (state)
            LOAD_A:  in_ready = 1'b1;
            LOAD_B:  in_ready = ACCUM ? ~acc_clr : 1'b1;
            default: in_ready = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= LOAD_A;
            reg_a     <= '0;
            reg_b     <= '0;
            out_sum   <= '0;
            out_carry <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            case (state)
                LOAD_A: begin
                    if (in_valid) begin
                        reg_a <= in_data;
                        state <= LOAD_B;
                    end
                end
                LOAD_B: begin
                    if (ACCUM && acc_clr) begin
                        state <= LOAD_A;
                    end else if (in_valid) begin
                        reg_b <= in_data;
                        state <= EXEC;
                    end
                end
                EXEC: begin
                    out_sum   <= add_sum;
                    out_carry <= add_carry;
                    out_valid <= 1'b1;
                    state     <= OUT;
                end
                OUT: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        if (ACCUM) begin
                            // Running total becomes the next A operand
                            reg_a <= out_sum;
                            state <= LOAD_B;
                        end else begin
                            state <= LOAD_A;
                        end
                    end
                end
                default: state <= LOAD_A;
            endcase
        end
    end

`ifdef ALU_ADD_SEQ_FLAGS_EN
    logic [2:0] flags_next;

    always_comb begin
        flags_next         = 3'b000;
        flags_next[FLAG_Z] = (add_sum == '0);
        flags_next[FLAG_N] = add_sum[DATA_W-1];
        // Signed overflow: like-signed operands producing an opposite-signed sum
        flags_next[FLAG_V] = (reg_a[DATA_W-1] == reg_b[DATA_W-1]) &&
                             (add_sum[DATA_W-1] != reg_a[DATA_W-1]);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_flags <= 3'b000;
        end else if (state == EXEC) begin
            out_flags <= flags_next;
        end
    end
`else
    assign out_flags = 3'b000;
`endif

endmodule

`default_nettype wire

// File: tb/tb_alu_add_seq.sv
// ============================================================================
// Module      : tb_alu_add_seq
// Description : Scoreboard bench for alu_add_seq. One instance with ACCUM=0
//               and one with ACCUM=1; expected results are queued when the
//               operands are issued and popped by per-instance monitors on
//               each result handshake. Expected flags follow the
//               ALU_ADD_SEQ_FLAGS_EN macro.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_alu_add_seq;

    typedef struct packed {
        logic [7:0] sum;
        logic       carry;
        logic [2:0] flags;
    } exp_t;

`ifdef ALU_ADD_SEQ_FLAGS_EN
    localparam bit FLAGS_ON = 1'b1;
`else
    localparam bit FLAGS_ON = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic       v0, rdy0, clr0, ov0, ordy0, c0;
    logic [7:0] d0, sum0;
    logic [2:0] f0;
    logic       v1, rdy1, clr1, ov1, ordy1, c1;
    logic [7:0] d1, sum1;
    logic [2:0] f1;

    alu_add_seq #(.ACCUM(1'b0)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .in_valid(v0), .in_ready(rdy0), .in_data(d0),
        .acc_clr(clr0), .out_valid(ov0), .out_ready(ordy0), .out_sum(sum0),
        .out_carry(c0), .out_flags(f0)
    );

    alu_add_seq #(.ACCUM(1'b1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .in_valid(v1), .in_ready(rdy1), .in_data(d1),
        .acc_clr(clr1), .out_valid(ov1), .out_ready(ordy1), .out_sum(sum1),
        .out_carry(c1), .out_flags(f1)
    );

    exp_t q0[$];
    exp_t q1[$];
    exp_t e0, e1;
    int   tests = 0;
    int   fails = 0;

    function automatic exp_t mk(input logic [7:0] s, input logic c, input logic [2:0] f);
        exp_t e;
        e.sum   = s;
        e.carry = c;
        e.flags = FLAGS_ON ? f : 3'b000;
        return e;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitors: one pop per result handshake (out_ready only changes just
    // after a rising edge, so it is stable from this sample to the edge).
    always @(negedge clk) begin
        if (rst_n && ov0 && ordy0) begin
            if (q0.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL dut0_unexpected: got sum %0h, expected no result", sum0);
            end else begin
                e0 = q0.pop_front();
                check("dut0_sum", 32'(sum0), 32'(e0.sum));
                check("dut0_carry", 32'(c0), 32'(e0.carry));
                check("dut0_flags", 32'(f0), 32'(e0.flags));
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n && ov1 && ordy1) begin
            if (q1.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL dut1_unexpected: got sum %0h, expected no result", sum1);
            end else begin
                e1 = q1.pop_front();
                check("dut1_sum", 32'(sum1), 32'(e1.sum));
                check("dut1_carry", 32'(c1), 32'(e1.carry));
                check("dut1_flags", 32'(f1), 32'(e1.flags));
            end
        end
    end

    // Present one byte and return just after the edge that accepts it.
    task automatic send(input int sel, input logic [7:0] b);
        int t;
        t = 0;
        @(negedge clk);
        if (sel == 0) begin v0 = 1'b1; d0 = b; end
        else          begin v1 = 1'b1; d1 = b; end
        while (!((sel == 0) ? rdy0 : rdy1)) begin
            @(negedge clk);
            t++;
            if (t > 50) begin
                tests++;
                fails++;
                $display("FAIL send_timeout: got in_ready 0, expected 1 (dut%0d)", sel);
                break;
            end
        end
        @(posedge clk);
        #1;
        if (sel == 0) v0 = 1'b0;
        else          v1 = 1'b0;
    endtask

    // Wait for the instance's scoreboard to drain and out_valid to drop.
    task automatic wait_idle(input int sel);
        int t;
        t = 0;
        while (((sel == 0) ? (q0.size() != 0 || ov0) : (q1.size() != 0 || ov1)) && t < 50) begin
            @(posedge clk);
            #1;
            t++;
        end
        check("idle_timeout", 32'(t < 50), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int t;
        rst_n = 1'b0;
        v0 = 1'b0; d0 = 8'h00; clr0 = 1'b0; ordy0 = 1'b1;
        v1 = 1'b0; d1 = 8'h00; clr1 = 1'b0; ordy1 = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_out_valid0", 32'(ov0), 32'd0);
        check("rst_sum0", 32'(sum0), 32'd0);
        check("rst_carry0", 32'(c0), 32'd0);
        check("rst_flags0", 32'(f0), 32'd0);
        check("rst_out_valid1", 32'(ov1), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("rst_in_ready0", 32'(rdy0), 32'd1);
        check("rst_in_ready1", 32'(rdy1), 32'd1);

        // 0x3C + 0x44: signed overflow into negative, with latency check
        q0.push_back(mk(8'h80, 1'b0, 3'b110));
        send(0, 8'h3C);
        send(0, 8'h44);
        check("lat_exec_valid", 32'(ov0), 32'd0);
        check("lat_exec_ready", 32'(rdy0), 32'd0);
        @(posedge clk);
        #1;
        check("lat_out_valid", 32'(ov0), 32'd1);
        check("lat_out_ready", 32'(rdy0), 32'd0);
        wait_idle(0);

        // 0xFF + 0x01: wrap to zero with carry
        q0.push_back(mk(8'h00, 1'b1, 3'b001));
        send(0, 8'hFF);
        send(0, 8'h01);
        wait_idle(0);

        // Backpressure: result held for 5 cycles with out_ready low
        ordy0 = 1'b0;
        q0.push_back(mk(8'h46, 1'b0, 3'b000));
        send(0, 8'h12);
        send(0, 8'h34);
        @(posedge clk);
        #1;
        for (int i = 0; i < 5; i++) begin
            check("bp_valid", 32'(ov0), 32'd1);
            check("bp_sum", 32'(sum0), 32'h46);
            check("bp_in_ready", 32'(rdy0), 32'd0);
            @(posedge clk);
            #1;
        end
        ordy0 = 1'b1;
        @(posedge clk);
        #1;
        check("bp_valid_drop", 32'(ov0), 32'd0);
        check("bp_in_ready_back", 32'(rdy0), 32'd1);
        wait_idle(0);

        // Accumulate: 0x10+0x20=0x30, then 0x30+0xE0=0x110
        q1.push_back(mk(8'h30, 1'b0, 3'b000));
        q1.push_back(mk(8'h10, 1'b1, 3'b000));
        send(1, 8'h10);
        send(1, 8'h20);
        send(1, 8'hE0);
        t = 0;
        @(negedge clk);
        while (!rdy1 && t < 50) begin
            @(negedge clk);
            t++;
        end
        check("acc_wait_ldb", 32'(rdy1), 32'd1);
        clr1 = 1'b1;
        #1;
        check("acc_clr_ready", 32'(rdy1), 32'd0);
        @(posedge clk);
        #1;
        clr1 = 1'b0;
        // Without the clear the 0x05 would be a B operand giving 0x15
        q1.push_back(mk(8'h0B, 1'b0, 3'b000));
        send(1, 8'h05);
        send(1, 8'h06);
        wait_idle(1);

        // Reset during EXEC: the pending result must never appear
        send(0, 8'h7F);
        send(0, 8'h01);
        rst_n = 1'b0;
        #1;
        check("mid_rst_valid", 32'(ov0), 32'd0);
        check("mid_rst_sum", 32'(sum0), 32'd0);
        check("mid_rst_carry", 32'(c0), 32'd0);
        check("mid_rst_flags", 32'(f0), 32'd0);
        repeat (2) begin
            @(posedge clk);
            #1;
            check("mid_rst_hold_valid", 32'(ov0), 32'd0);
        end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("post_rst_ready", 32'(rdy0), 32'd1);
        repeat (3) begin
            @(posedge clk);
            #1;
            check("post_rst_no_valid", 32'(ov0), 32'd0);
        end
        q0.push_back(mk(8'h03, 1'b0, 3'b000));
        send(0, 8'h01);
        send(0, 8'h02);
        wait_idle(0);

        check("q0_empty", 32'(q0.size()), 32'd0);
        check("q1_empty", 32'(q1.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

`default_nettype wire
